// File: rtl/sample_acc_relu_14.sv
// -----------------------------------------------------------------------------
// sample_acc_relu_14
// Accumulates N_TERMS signed products plus a bias, then saturates the sum to
// DOUT_WIDTH and applies an optional ReLU. One result is produced per frame
// and is presented on a registered valid/ready output.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous, active-high reset
//   ce        - clock enable; all state holds while low
//   din       - signed product from the multiplier
//   din_vld   - din is valid this cycle
//   din_rdy   - stage can take a term this cycle (combinational)
//   bias      - signed bias, captured with the first term of a frame
//   dout      - formatted result (registered)
//   dout_vld  - result valid (registered)
//   dout_rdy  - downstream takes the result
//   sat       - result was saturated, qualified by dout_vld
// -----------------------------------------------------------------------------
module sample_acc_relu_14 #(
    parameter int DIN_WIDTH  = 14,
    parameter int ACC_WIDTH  = 24,
    parameter int DOUT_WIDTH = 14,
    parameter int N_TERMS    = 16,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic [DIN_WIDTH-1:0]  bias,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  sat
);

    localparam int CNT_WIDTH = $clog2(N_TERMS + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N_TERMS - 1);

    // Output range expressed at accumulator width for the saturation compare.
    localparam logic signed [ACC_WIDTH-1:0] DOUT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] DOUT_MIN =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DOUT_WIDTH-1:0]   dout_q, dout_d;
    logic                    dout_vld_q, dout_vld_d;
    logic                    sat_q, sat_d;

    logic                    accept_s;
    logic                    xfer_s;
    logic                    frame_start_s;
    logic                    term_add_s;
    logic                    bad_state_s;
    logic [ACC_WIDTH-1:0]    first_sum_s;
    logic [ACC_WIDTH-1:0]    next_sum_s;
    logic [DOUT_WIDTH:0]     fmt_first_s;
    logic [DOUT_WIDTH:0]     fmt_next_s;

    // Sign-extend a DIN_WIDTH value to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] sext(input logic [DIN_WIDTH-1:0] v);
        return {{(ACC_WIDTH-DIN_WIDTH){v[DIN_WIDTH-1]}}, v};
    endfunction

    // Saturate and optionally ReLU a final sum; returns {sat, value}.
    // ReLU zeroes the value but the saturation flag is kept.
    function automatic logic [DOUT_WIDTH:0] fmt_result(input logic [ACC_WIDTH-1:0] sum);
        logic signed [ACC_WIDTH-1:0] s;
        logic [DOUT_WIDTH-1:0]       val;
        logic                        sat_f;
        s = signed'(sum);
        if (s > DOUT_MAX) begin
            val   = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            sat_f = 1'b1;
        end else if (s < DOUT_MIN) begin
            val   = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            sat_f = 1'b1;
        end else begin
            val   = sum[DOUT_WIDTH-1:0];
            sat_f = 1'b0;
        end
        if ((RELU_EN != 0) && val[DOUT_WIDTH-1]) begin
            val = {DOUT_WIDTH{1'b0}};
        end else begin
            val = val;
        end
        return {sat_f, val};
    endfunction

    // Handshake terms. In OUT a term is only taken when the held result retires.
    assign din_rdy  = (state_q == OUT) ? dout_rdy : 1'b1;
    assign accept_s = ce & din_vld & din_rdy;
    assign xfer_s   = ce & dout_vld_q & dout_rdy;

    assign first_sum_s = sext(bias) + sext(din);
    assign next_sum_s  = acc_q + sext(din);
    assign fmt_first_s = fmt_result(first_sum_s);
    assign fmt_next_s  = fmt_result(next_sum_s);

    // Next-state and datapath update for the IDLE/ACC/OUT frame sequencer.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        dout_vld_d    = dout_vld_q;
        sat_d         = sat_q;
        frame_start_s = 1'b0;
        term_add_s    = 1'b0;
        bad_state_s   = 1'b0;

        case (state_q)
            IDLE:    frame_start_s = accept_s;
            ACC:     term_add_s    = accept_s;
            // accept in OUT implies dout_rdy, so the held result retires too.
            OUT:     frame_start_s = accept_s;
            default: bad_state_s   = 1'b1;
        endcase

        if (frame_start_s) begin
            acc_d = first_sum_s;
            cnt_d = CNT_WIDTH'(1);
            if (N_TERMS == 1) begin
                dout_d     = fmt_first_s[DOUT_WIDTH-1:0];
                sat_d      = fmt_first_s[DOUT_WIDTH];
                dout_vld_d = 1'b1;
                state_d    = OUT;
            end else begin
                dout_vld_d = 1'b0;
                state_d    = ACC;
            end
        end else if (term_add_s) begin
            acc_d = next_sum_s;
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_CNT) begin
                dout_d     = fmt_next_s[DOUT_WIDTH-1:0];
                sat_d      = fmt_next_s[DOUT_WIDTH];
                dout_vld_d = 1'b1;
                state_d    = OUT;
            end else begin
                state_d    = ACC;
            end
        end else if (xfer_s) begin
            dout_vld_d = 1'b0;
            state_d    = IDLE;
        end else if (bad_state_s) begin
            dout_vld_d = 1'b0;
            cnt_d      = {CNT_WIDTH{1'b0}};
            state_d    = IDLE;
        end else begin
            state_d    = state_q;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= {ACC_WIDTH{1'b0}};
            cnt_q      <= {CNT_WIDTH{1'b0}};
            dout_q     <= {DOUT_WIDTH{1'b0}};
            dout_vld_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            sat_q      <= sat_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_sample_acc_relu_14.sv
// -----------------------------------------------------------------------------
// tb_sample_acc_relu_14
// Drives one shared input stream into five configurations of the accumulator
// (N_TERMS / RELU_EN = 4/1, 4/0, 16/1, 16/0, 1/0) and compares every cycle
// against a frame-level reference model, plus directed constant checks.
// -----------------------------------------------------------------------------
module tb_sample_acc_relu_14;

    localparam int ND = 5;
    localparam logic [ND-1:0][7:0] NT_P = {8'd1, 8'd16, 8'd16, 8'd4, 8'd4};
    localparam logic [ND-1:0][7:0] RL_P = {8'd0, 8'd0, 8'd1, 8'd0, 8'd1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [13:0] din = 14'd0;
    logic        din_vld = 1'b0;
    logic [13:0] bias = 14'd0;
    logic        dout_rdy = 1'b0;

    logic [13:0] dout_w     [ND];
    logic        dout_vld_w [ND];
    logic        sat_w      [ND];
    logic        din_rdy_w  [ND];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: pending result and running frame sum per DUT.
    int          m_nt   [ND] = '{4, 4, 16, 16, 1};
    bit          m_relu [ND] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          m_vld  [ND];
    logic [13:0] m_dout [ND];
    bit          m_sat  [ND];
    int          m_n    [ND];
    longint      m_sum  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sample_acc_relu_14 #(
            .N_TERMS (int'(NT_P[g])),
            .RELU_EN (int'(RL_P[g]))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .ce       (ce),
            .din      (din),
            .din_vld  (din_vld),
            .din_rdy  (din_rdy_w[g]),
            .bias     (bias),
            .dout     (dout_w[g]),
            .dout_vld (dout_vld_w[g]),
            .dout_rdy (dout_rdy),
            .sat      (sat_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ND; i++) begin
            m_vld[i]  = 1'b0;
            m_dout[i] = 14'd0;
            m_sat[i]  = 1'b0;
            m_n[i]    = 0;
            m_sum[i]  = 0;
        end
    endtask

    // Saturate to [-8192, 8191], then optional ReLU.
    task automatic model_fmt(input int i);
        longint v;
        bit     s;
        if (m_sum[i] > 8191) begin
            v = 8191;
            s = 1'b1;
        end else if (m_sum[i] < -8192) begin
            v = -8192;
            s = 1'b1;
        end else begin
            v = m_sum[i];
            s = 1'b0;
        end
        if (m_relu[i] && v < 0) v = 0;
        m_dout[i] = v[13:0];
        m_sat[i]  = s;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s_vld_d%0d", tag, i), 32'(dout_vld_w[i]), 32'(m_vld[i]));
            if (m_vld[i]) begin
                chk($sformatf("%s_dout_d%0d", tag, i), 32'(dout_w[i]), 32'(m_dout[i]));
                chk($sformatf("%s_sat_d%0d", tag, i), 32'(sat_w[i]), 32'(m_sat[i]));
            end
        end
    endtask

    // One clock cycle: drive at negedge, check din_rdy, model the edge, check outputs.
    task automatic step(input logic c, input logic v, input int d, input int b, input logic r);
        bit     rdy_e [ND];
        longint sd, sb;
        ce       = c;
        din_vld  = v;
        din      = 14'(d);
        bias     = 14'(b);
        dout_rdy = r;
        sd = longint'($signed(din));
        sb = longint'($signed(bias));
        #1;
        for (int i = 0; i < ND; i++) begin
            rdy_e[i] = m_vld[i] ? r : 1'b1;
            chk($sformatf("din_rdy_d%0d", i), 32'(din_rdy_w[i]), 32'(rdy_e[i]));
        end
        @(posedge clk);
        for (int i = 0; i < ND; i++) begin
            if (c && m_vld[i] && r) m_vld[i] = 1'b0;
            if (c && v && rdy_e[i]) begin
                if (m_n[i] == 0) m_sum[i] = sb + sd;
                else             m_sum[i] = m_sum[i] + sd;
                m_n[i]++;
                if (m_n[i] == m_nt[i]) begin
                    model_fmt(i);
                    m_vld[i] = 1'b1;
                    m_n[i]   = 0;
                end
            end
        end
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    // Reset pulse placed strictly between clock edges; outputs must clear at once.
    task automatic async_reset();
        ce      = 1'b0;
        din_vld = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("arst_vld_d%0d", i), 32'(dout_vld_w[i]), 32'd0);
            chk($sformatf("arst_dout_d%0d", i), 32'(dout_w[i]), 32'd0);
            chk($sformatf("arst_sat_d%0d", i), 32'(sat_w[i]), 32'd0);
        end
        model_clear();
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t1 [4] = '{100, 200, -50, 5};
        int t3 [4] = '{10, 20, 30, -5};
        model_clear();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst_vld_d%0d", i), 32'(dout_vld_w[i]), 32'd0);
            chk($sformatf("rst_dout_d%0d", i), 32'(dout_w[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Basic frame, then the result must drop after one cycle.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, t1[k], 10, 1'b1);
        chk("t1_dout", 32'(dout_w[0]), 32'd265);
        chk("t1_sat", 32'(sat_w[0]), 32'd0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("t1_vld_low", 32'(dout_vld_w[0]), 32'd0);

        // Positive and negative saturation with 16 terms.
        async_reset();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 8191, 0, 1'b1);
        chk("t2_pos_dout", 32'(dout_w[2]), 32'd8191);
        chk("t2_pos_sat", 32'(sat_w[2]), 32'd1);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, -8192, 0, 1'b1);
        chk("t2_neg_dout", 32'(dout_w[3]), 32'h2000);
        chk("t2_neg_sat", 32'(sat_w[3]), 32'd1);
        chk("t2_neg_relu", 32'(dout_w[2]), 32'd0);

        // Negative unsaturated sum, with and without ReLU.
        async_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, t3[k], -100, 1'b1);
        chk("t3_relu_dout", 32'(dout_w[0]), 32'd0);
        chk("t3_relu_sat", 32'(sat_w[0]), 32'd0);
        chk("t3_raw_dout", 32'(dout_w[1]), 32'h3FD3);

        // Backpressure then retire-and-accept in the same cycle.
        async_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, t1[k], 10, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 999, 0, 1'b0);
        chk("t4_hold_dout", 32'(dout_w[0]), 32'd265);
        chk("t4_hold_rdy", 32'(din_rdy_w[0]), 32'd0);
        step(1'b1, 1'b1, 1, -3, 1'b1);
        step(1'b1, 1'b1, 2, 0, 1'b1);
        step(1'b1, 1'b1, 3, 0, 1'b1);
        step(1'b1, 1'b1, 4, 0, 1'b1);
        chk("t4_next_dout", 32'(dout_w[0]), 32'd7);

        // Clock enable dropped mid-frame.
        async_reset();
        step(1'b1, 1'b1, 100, 10, 1'b1);
        step(1'b1, 1'b1, 200, 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 555, 0, 1'b1);
        step(1'b1, 1'b1, -50, 0, 1'b1);
        step(1'b1, 1'b1, 5, 0, 1'b1);
        chk("t5_dout", 32'(dout_w[0]), 32'd265);

        // Reset with a held result, then with a partial frame.
        async_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, t1[k], 10, 1'b0);
        async_reset();
        step(1'b1, 1'b1, 7, 7, 1'b1);
        step(1'b1, 1'b1, 7, 7, 1'b1);
        async_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1, 0, 1'b1);
        chk("t6_dout", 32'(dout_w[0]), 32'd4);
        chk("t6_dout_raw", 32'(dout_w[1]), 32'd4);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic c, v, r;
            int   d, b;
            c = ($urandom_range(9, 0) != 0);
            v = ($urandom_range(9, 0) < 7);
            r = ($urandom_range(9, 0) < 7);
            if ($urandom_range(1, 0) == 1) d = $urandom_range(16383, 0) - 8192;
            else                           d = $urandom_range(600, 0) - 300;
            b = $urandom_range(16383, 0) - 8192;
            step(c, v, d, b, r);
            if ($urandom_range(499, 0) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
